// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC sequencing controller.
// The CRC_PAR2_EN macro (see crc_seq_ctrl) selects the two-bit-per-cycle variant.
package crc_pkg;

  localparam int unsigned MSG_W = 60;
  localparam int unsigned W5    = 5;
  localparam int unsigned W8    = 8;
  localparam int unsigned CRC_W = 8;

  localparam logic [W5-1:0] POLY5 = 5'h05;
  localparam logic [W8-1:0] POLY8 = 8'h07;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_seq_ctrl_if.sv
// Request/result bundle between the capture stage (master) and the CRC controller (slave).
interface crc_seq_ctrl_if #(
  parameter int unsigned MSG_W = crc_pkg::MSG_W
);
  import crc_pkg::*;

  logic             start;
  logic [MSG_W-1:0] message;
  logic             mode;
  logic             crc_sel;
  logic             busy;
  logic             out_valid;
  logic [CRC_W-1:0] crc_out;
  logic             chk_pass;
  logic             overrun;

  modport master (
    output start, message, mode, crc_sel,
    input  busy, out_valid, crc_out, chk_pass, overrun
  );

  modport slave (
    input  start, message, mode, crc_sel,
    output busy, out_valid, crc_out, chk_pass, overrun
  );

endinterface

// File: rtl/crc_lfsr_step.sv
// One MSB-first, non-reflected LFSR step for CRC-5 (0x05) or CRC-8 (0x07).
module crc_lfsr_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] lfsr_in,
  input  logic             data_bit,
  input  logic             crc_sel,
  output logic [CRC_W-1:0] lfsr_out
);

  logic fb;

  // Bits above the active width stay zero so CRC-5 results are zero-extended.
  always_comb begin
    fb       = 1'b0;
    lfsr_out = '0;
    if (crc_sel) begin
      fb       = lfsr_in[W8-1] ^ data_bit;
      lfsr_out = {lfsr_in[W8-2:0], 1'b0} ^ (fb ? POLY8 : 8'h00);
    end else begin
      fb       = lfsr_in[W5-1] ^ data_bit;
      lfsr_out = {3'b000, lfsr_in[W5-2:0], 1'b0} ^ {3'b000, (fb ? POLY5 : 5'h00)};
    end
  end

endmodule

// File: rtl/crc_seq_ctrl.sv
// Sequences the bit-serial CRC engine over one captured message (generate or check).
// Define CRC_PAR2_EN to consume two message bits per SHIFT cycle (MSG_W must be even).
module crc_seq_ctrl #(
  parameter int unsigned MSG_W = crc_pkg::MSG_W
) (
  input  logic          clk_2,
  input  logic          rst,
  crc_seq_ctrl_if.slave bus
);
  import crc_pkg::*;

  localparam int unsigned CNT_W = $clog2(MSG_W + 1);
`ifdef CRC_PAR2_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - STEP);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(STEP);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       state, state_n;
  logic [MSG_W-1:0] sreg, sreg_n;
  logic [CRC_W-1:0] lfsr, lfsr_n, lfsr_adv;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             mode_q, mode_n, sel_q, sel_n;
  logic             busy_n, valid_n, pass_n, ovr_n;
  logic [CRC_W-1:0] crc_n;
  logic [CRC_W-1:0] step1;

  crc_lfsr_step u_step0 (
    .lfsr_in  (lfsr),
    .data_bit (sreg[MSG_W-1]),
    .crc_sel  (sel_q),
    .lfsr_out (step1)
  );

`ifdef CRC_PAR2_EN
  logic [CRC_W-1:0] step2;

  crc_lfsr_step u_step1 (
    .lfsr_in  (step1),
    .data_bit (sreg[MSG_W-2]),
    .crc_sel  (sel_q),
    .lfsr_out (step2)
  );

  assign lfsr_adv = step2;
`else
  assign lfsr_adv = step1;
`endif

  always_ff @(posedge clk_2) begin
    if (rst) begin
      state         <= ST_IDLE;
      sreg          <= '0;
      lfsr          <= '0;
      cnt           <= '0;
      mode_q        <= 1'b0;
      sel_q         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.crc_out   <= '0;
      bus.chk_pass  <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state         <= state_n;
      sreg          <= sreg_n;
      lfsr          <= lfsr_n;
      cnt           <= cnt_n;
      mode_q        <= mode_n;
      sel_q         <= sel_n;
      bus.busy      <= busy_n;
      bus.out_valid <= valid_n;
      bus.crc_out   <= crc_n;
      bus.chk_pass  <= pass_n;
      bus.overrun   <= ovr_n;
    end
  end

  // Next-state and next-output logic; a start outside IDLE only raises overrun.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    mode_n  = mode_q;
    sel_n   = sel_q;
    busy_n  = bus.busy;
    valid_n = 1'b0;
    crc_n   = bus.crc_out;
    pass_n  = bus.chk_pass;
    ovr_n   = bus.overrun | (bus.start & (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          sreg_n  = bus.message;
          mode_n  = bus.mode;
          sel_n   = bus.crc_sel;
          lfsr_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_n = sreg << STEP;
        lfsr_n = lfsr_adv;
        cnt_n  = cnt + CNT_INC;
        if (cnt == CNT_LAST) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_n = 1'b1;
        crc_n   = lfsr;
        pass_n  = mode_q & (lfsr == '0);
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Self-checking bench for crc_seq_ctrl against a polynomial-division reference model.
module tb_crc_seq_ctrl;

  localparam int unsigned MSG_W = 60;
`ifdef CRC_PAR2_EN
  localparam int LAT = 31;
`else
  localparam int LAT = 61;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  crc_seq_ctrl_if bus ();

  crc_seq_ctrl dut (
    .clk_2 (clk),
    .rst   (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] rnd60();
    return 60'({$urandom(), $urandom()});
  endfunction

  // Remainder of M(x)*x^W divided by the generator, by plain mod-2 long division.
  function automatic logic [7:0] ref_crc(input logic [59:0] m, input logic sel);
    int          w;
    logic [71:0] r;
    logic [71:0] g;
    w = sel ? 8 : 5;
    g = sel ? 72'h107 : 72'h025;
    r = 72'(m) << w;
    for (int i = 71; i >= w; i--) begin
      if (r[i]) r = r ^ (g << (i - w));
    end
    return 8'(r);
  endfunction

  task automatic run_job(input logic [59:0] m, input logic md, input logic sel, input string tag);
    logic [7:0] exp_crc;
    int         cyc;
    bit         seen;
    exp_crc     = ref_crc(m, sel);
    bus.message = m;
    bus.mode    = md;
    bus.crc_sel = sel;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      bus.message = rnd60();
      bus.mode    = 1'($urandom_range(0, 1));
      bus.crc_sel = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (bus.out_valid) seen = 1;
    end
    check({tag, "_lat"}, 64'(seen ? cyc : -1), 64'(LAT));
    check({tag, "_crc"}, 64'(bus.crc_out), 64'(exp_crc));
    check({tag, "_pass"}, 64'(bus.chk_pass), 64'(md && exp_crc == 8'h00));
    tick();
    check({tag, "_vld_pulse"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] m;
    logic [59:0] p;
    logic        md;
    logic        sel;
    logic [7:0]  exp_a;
    logic [7:0]  got_crc;
    int          pulses;
    int          w;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.message = '0;
    bus.mode    = 1'b0;
    bus.crc_sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_crc", 64'(bus.crc_out), 64'd0);
    check("rst_pass", 64'(bus.chk_pass), 64'd0);
    check("rst_ovr", 64'(bus.overrun), 64'd0);

    run_job(60'h1, 1'b0, 1'b1, "gen8_one");
    check("gen8_one_val", 64'(bus.crc_out), 64'h07);
    run_job(60'h0, 1'b0, 1'b1, "gen8_zero");
    run_job(60'h1, 1'b0, 1'b0, "gen5_one");
    check("gen5_one_val", 64'(bus.crc_out), 64'h05);
    run_job(60'h107, 1'b1, 1'b1, "chk8_ok");
    check("chk8_ok_val", 64'(bus.chk_pass), 64'd1);
    run_job(60'h106, 1'b1, 1'b1, "chk8_bad");
    check("chk8_bad_nz", 64'(bus.crc_out != 8'h00), 64'd1);
    run_job(60'h25, 1'b1, 1'b0, "chk5_ok");
    check("chk5_ok_val", 64'(bus.chk_pass), 64'd1);
    run_job({60{1'b1}}, 1'b0, 1'b1, "gen8_ones");

    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom_range(0, 1));
      md  = 1'($urandom_range(0, 1));
      m   = rnd60();
      if (md && $urandom_range(0, 1) == 1) begin
        w = sel ? 8 : 5;
        p = m >> w;
        m = (p << w) | 60'(ref_crc(p, sel));
      end
      run_job(m, md, sel, $sformatf("rnd%0d", k));
    end

    // Start arriving mid-job must be ignored and flagged.
    m           = rnd60();
    exp_a       = ref_crc(m, 1'b1);
    bus.message = m;
    bus.mode    = 1'b0;
    bus.crc_sel = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.message = rnd60();
    bus.crc_sel = 1'b0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses    = 0;
    got_crc   = 8'h00;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (bus.out_valid) begin
        pulses++;
        got_crc = bus.crc_out;
      end
    end
    check("ovr_pulses", 64'(pulses), 64'd1);
    check("ovr_crc", 64'(got_crc), 64'(exp_a));
    check("ovr_flag", 64'(bus.overrun), 64'd1);
    run_job(60'h1, 1'b0, 1'b1, "after_ovr");
    check("ovr_sticky", 64'(bus.overrun), 64'd1);

    // Reset in the middle of SHIFT aborts the job.
    bus.message = rnd60();
    bus.mode    = 1'b1;
    bus.crc_sel = 1'b1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_crc", 64'(bus.crc_out), 64'd0);
    check("abort_ovr", 64'(bus.overrun), 64'd0);
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
    run_job(60'h25, 1'b1, 1'b0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
